// File: rtl/ecap5_dproc_pkg.sv
// Shared types for the data-processor bus fabric.
// bus_grant_t encodes which master currently owns the Wishbone memory port.
package ecap5_dproc_pkg;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_M0   = 2'd1,
    GRANT_M1   = 2'd2
  } bus_grant_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the pipelined Wishbone memory port.
// M1 (load/store) has priority. M0 (fetch) wins once M1 has won STARVE_LIMIT contended rounds in a row.
module mem_arbiter
  import ecap5_dproc_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_stall_o,

  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_stall_o,

  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_stall_i,

  output bus_grant_t  grant_o
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  bus_grant_t          grant_q, grant_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                arb_en;
  logic                starved;

  assign starved = (starve_q == STARVE_W'(STARVE_LIMIT));

  // Re-arbitrate only when nobody holds the bus or the owner has closed its cycle.
  assign arb_en = (grant_q == GRANT_NONE)
               || ((grant_q == GRANT_M0) && !m0_cyc_i)
               || ((grant_q == GRANT_M1) && !m1_cyc_i);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    grant_d  = grant_q;
    starve_d = starve_q;
    if (arb_en) begin
      if (m0_cyc_i && m1_cyc_i) begin
        grant_d = starved ? GRANT_M0 : GRANT_M1;
      end else if (m0_cyc_i) begin
        grant_d = GRANT_M0;
      end else if (m1_cyc_i) begin
        grant_d = GRANT_M1;
      end else begin
        grant_d = GRANT_NONE;
      end

      if (grant_d == GRANT_M0) begin
        starve_d = '0;
      end else if ((grant_d == GRANT_M1) && m0_cyc_i && !starved) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant_q  <= GRANT_NONE;
      starve_q <= '0;
    end else begin
      grant_q  <= grant_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    wb_adr_o = '0;
    wb_dat_o = '0;
    wb_we_o  = 1'b0;
    wb_sel_o = '0;
    wb_stb_o = 1'b0;
    wb_cyc_o = 1'b0;
    unique case (grant_q)
      GRANT_M0: begin
        wb_adr_o = m0_adr_i;
        wb_dat_o = m0_dat_i;
        wb_we_o  = m0_we_i;
        wb_sel_o = m0_sel_i;
        wb_stb_o = m0_stb_i;
        wb_cyc_o = m0_cyc_i;
      end
      GRANT_M1: begin
        wb_adr_o = m1_adr_i;
        wb_dat_o = m1_dat_i;
        wb_we_o  = m1_we_i;
        wb_sel_o = m1_sel_i;
        wb_stb_o = m1_stb_i;
        wb_cyc_o = m1_cyc_i;
      end
      default: ;
    endcase
  end

  // A master without the grant sees a permanent stall, which holds its request in place.
  assign m0_stall_o = (grant_q == GRANT_M0) ? wb_stall_i : 1'b1;
  assign m1_stall_o = (grant_q == GRANT_M1) ? wb_stall_i : 1'b1;
  assign m0_ack_o   = (grant_q == GRANT_M0) && wb_ack_i;
  assign m1_ack_o   = (grant_q == GRANT_M1) && wb_ack_i;
  assign m0_dat_o   = wb_dat_i;
  assign m1_dat_o   = wb_dat_i;
  assign grant_o    = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected bus transfers and acks into queues,
// a negedge monitor pops and compares them whenever the DUT accepts a transfer or raises an ack.
module tb_mem_arbiter;
  import ecap5_dproc_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
  logic        m0_we_i, m0_stb_i, m0_cyc_i, m1_we_i, m1_stb_i, m1_cyc_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_stall_o, m1_ack_o, m1_stall_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic        wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i, wb_stall_i;
  logic [3:0]  wb_sel_o;
  bus_grant_t  grant_o;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_stall_o(m0_stall_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_stall_o(m1_stall_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_stall_i(wb_stall_i),
    .grant_o(grant_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bus_grant_t  grant;
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } xfer_t;

  typedef struct {
    logic [1:0]  who;  // {m1_ack, m0_ack}
    logic [31:0] dat;
  } ack_t;

  xfer_t xfer_q[$];
  ack_t  ack_q[$];
  xfer_t mon_x;
  ack_t  mon_a;
  int    n_cmp  = 0;
  int    n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  task automatic drive_m(input int m, input logic cyc, input logic stb, input logic [31:0] adr,
                         input logic we, input logic [3:0] sel, input logic [31:0] dat);
    if (m == 0) begin
      m0_cyc_i = cyc; m0_stb_i = stb; m0_adr_i = adr; m0_we_i = we; m0_sel_i = sel; m0_dat_i = dat;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_adr_i = adr; m1_we_i = we; m1_sel_i = sel; m1_dat_i = dat;
    end
  endtask

  task automatic push_x(input bus_grant_t g, input logic [31:0] adr, input logic we,
                        input logic [3:0] sel, input logic [31:0] dat);
    xfer_t x;
    x.grant = g; x.adr = adr; x.we = we; x.sel = sel; x.dat = dat;
    xfer_q.push_back(x);
  endtask

  task automatic push_a(input logic [1:0] who, input logic [31:0] dat);
    ack_t a;
    a.who = who; a.dat = dat;
    ack_q.push_back(a);
  endtask

  // Monitor: an accepted transfer is cyc & stb & !stall on the slave side.
  always @(negedge clk_i) begin
    if (wb_cyc_o && wb_stb_o && !wb_stall_i) begin
      check("xfer_expected", xfer_q.size() > 0, 1'b1);
      if (xfer_q.size() > 0) begin
        mon_x = xfer_q.pop_front();
        check("xfer_grant", grant_o, mon_x.grant);
        check("xfer_adr",   wb_adr_o, mon_x.adr);
        check("xfer_we",    wb_we_o,  mon_x.we);
        check("xfer_sel",   wb_sel_o, mon_x.sel);
        check("xfer_dat",   wb_dat_o, mon_x.dat);
      end
    end
    if (m0_ack_o || m1_ack_o) begin
      check("ack_expected", ack_q.size() > 0, 1'b1);
      if (ack_q.size() > 0) begin
        mon_a = ack_q.pop_front();
        check("ack_route", {m1_ack_o, m0_ack_o}, mon_a.who);
        check("ack_data", m1_ack_o ? m1_dat_o : m0_dat_o, mon_a.dat);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_grant_t win;
    rst_i = 1'b1;
    drive_m(0, 0, 0, 0, 0, 0, 0);
    drive_m(1, 0, 0, 0, 0, 0, 0);
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_stall_i = 1'b0;

    // Reset state
    repeat (2) next();
    smp();
    check("rst_grant",   grant_o, GRANT_NONE);
    check("rst_cyc",     wb_cyc_o, 1'b0);
    check("rst_adr",     wb_adr_o, 32'h0);
    check("rst_m0_stall", m0_stall_o, 1'b1);
    check("rst_m1_stall", m1_stall_o, 1'b1);
    next();
    rst_i = 1'b0;

    // Lone M0 read: one-cycle request-to-grant latency, ack only to M0
    next();
    drive_m(0, 1, 1, 32'h100, 0, 4'hF, 0);
    push_x(GRANT_M0, 32'h100, 0, 4'hF, 0);
    smp();
    check("t2_grant_pre", grant_o, GRANT_NONE);
    check("t2_m0_stall_pre", m0_stall_o, 1'b1);
    check("t2_cyc_pre", wb_cyc_o, 1'b0);
    next(); smp();
    check("t2_grant", grant_o, GRANT_M0);
    check("t2_adr", wb_adr_o, 32'h100);
    check("t2_m0_stall", m0_stall_o, 1'b0);
    next();
    drive_m(0, 1, 0, 32'h100, 0, 4'hF, 0);
    wb_ack_i = 1'b1; wb_dat_i = 32'hDEADBEEF;
    push_a(2'b01, 32'hDEADBEEF);
    smp();
    check("t2_m1_ack", m1_ack_o, 1'b0);
    next();
    wb_ack_i = 1'b0;
    drive_m(0, 0, 0, 0, 0, 0, 0);
    smp();
    check("t2_hold_release_cycle", grant_o, GRANT_M0);
    next(); smp();
    check("t2_idle", grant_o, GRANT_NONE);

    // Contention: M1 wins, M0 takes over the cycle right after M1 drops cyc
    next();
    drive_m(0, 1, 1, 32'h200, 0, 4'hF, 0);
    drive_m(1, 1, 1, 32'h300, 1, 4'h3, 32'h11112222);
    push_x(GRANT_M1, 32'h300, 1, 4'h3, 32'h11112222);
    smp();
    check("t3_grant_pre", grant_o, GRANT_NONE);
    next(); smp();
    check("t3_grant_m1", grant_o, GRANT_M1);
    check("t3_m0_stall", m0_stall_o, 1'b1);
    next();
    drive_m(1, 1, 0, 32'h300, 1, 4'h3, 32'h11112222);
    wb_ack_i = 1'b1; wb_dat_i = 32'h0;
    push_a(2'b10, 32'h0);
    smp();
    check("t3_m0_stall_hold", m0_stall_o, 1'b1);
    check("t3_m0_ack", m0_ack_o, 1'b0);
    next();
    wb_ack_i = 1'b0;
    drive_m(1, 0, 0, 0, 0, 0, 0);
    push_x(GRANT_M0, 32'h200, 0, 4'hF, 0);
    smp();
    check("t3_release_cycle", grant_o, GRANT_M1);
    check("t3_m0_stall_release", m0_stall_o, 1'b1);
    next(); smp();
    check("t3_no_gap", grant_o, GRANT_M0);
    next();
    drive_m(0, 1, 0, 32'h200, 0, 4'hF, 0);
    wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE0001;
    push_a(2'b01, 32'hCAFE0001);
    next();
    wb_ack_i = 1'b0;
    drive_m(0, 0, 0, 0, 0, 0, 0);
    next(); smp();
    check("t3_idle", grant_o, GRANT_NONE);

    // Starvation: both contend from idle each round. M1 wins four rounds,
    // M0 wins the fifth, and with the counter cleared M1 wins the sixth.
    // The loser withdraws when the winner finishes so every round starts from idle.
    for (int r = 0; r < 6; r++) begin
      win = (r == 4) ? GRANT_M0 : GRANT_M1;
      next();
      drive_m(0, 1, 1, 32'h1000 + r, 0, 4'hF, 0);
      drive_m(1, 1, 1, 32'h2000 + r, 1, 4'hC, 32'hA5A50000 + r);
      if (win == GRANT_M0) push_x(GRANT_M0, 32'h1000 + r, 0, 4'hF, 0);
      else                 push_x(GRANT_M1, 32'h2000 + r, 1, 4'hC, 32'hA5A50000 + r);
      smp();
      check("t4_grant_pre", grant_o, GRANT_NONE);
      next(); smp();
      check("t4_winner", grant_o, win);
      next();
      if (win == GRANT_M0) drive_m(0, 1, 0, 32'h1000 + r, 0, 4'hF, 0);
      else                 drive_m(1, 1, 0, 32'h2000 + r, 1, 4'hC, 32'hA5A50000 + r);
      wb_ack_i = 1'b1; wb_dat_i = 32'h7700 + r;
      push_a((win == GRANT_M0) ? 2'b01 : 2'b10, 32'h7700 + r);
      next();
      wb_ack_i = 1'b0;
      drive_m(0, 0, 0, 0, 0, 0, 0);
      drive_m(1, 0, 0, 0, 0, 0, 0);
      next(); smp();
      check("t4_idle", grant_o, GRANT_NONE);
    end

    // Stall pass-through: three stalled cycles keep stb on the bus
    next();
    wb_stall_i = 1'b1;
    drive_m(1, 1, 1, 32'h400, 0, 4'hF, 0);
    push_x(GRANT_M1, 32'h400, 0, 4'hF, 0);
    next();
    for (int i = 0; i < 3; i++) begin
      smp();
      check("t5_m1_stall", m1_stall_o, 1'b1);
      check("t5_m0_stall", m0_stall_o, 1'b1);
      check("t5_stb", wb_stb_o, 1'b1);
      check("t5_adr", wb_adr_o, 32'h400);
      next();
    end
    wb_stall_i = 1'b0;
    smp();
    check("t5_m1_stall_release", m1_stall_o, 1'b0);
    next();
    drive_m(1, 1, 0, 32'h400, 0, 4'hF, 0);
    wb_ack_i = 1'b1; wb_dat_i = 32'h5;
    push_a(2'b10, 32'h5);
    next();
    wb_ack_i = 1'b0;
    drive_m(1, 0, 0, 0, 0, 0, 0);
    next(); smp();
    check("t5_idle", grant_o, GRANT_NONE);

    // Stray ack with no grant is dropped
    next();
    wb_ack_i = 1'b1; wb_dat_i = 32'hBAD;
    smp();
    check("t6_m0_ack", m0_ack_o, 1'b0);
    check("t6_m1_ack", m1_ack_o, 1'b0);
    check("t6_grant", grant_o, GRANT_NONE);
    next();
    wb_ack_i = 1'b0;
    smp();
    check("t6_grant_after", grant_o, GRANT_NONE);

    // Asynchronous reset in the middle of a stalled M1 cycle
    next();
    wb_stall_i = 1'b1;
    drive_m(1, 1, 1, 32'h500, 1, 4'hF, 32'h55);
    next(); smp();
    check("t1_grant_before", grant_o, GRANT_M1);
    check("t1_cyc_before", wb_cyc_o, 1'b1);
    #2;
    rst_i = 1'b1;
    wb_ack_i = 1'b1;
    #1;
    check("t1_cyc", wb_cyc_o, 1'b0);
    check("t1_m0_stall", m0_stall_o, 1'b1);
    check("t1_m1_stall", m1_stall_o, 1'b1);
    check("t1_grant", grant_o, GRANT_NONE);
    check("t1_m1_ack", m1_ack_o, 1'b0);
    check("t1_adr", wb_adr_o, 32'h0);
    next();
    wb_ack_i = 1'b0;
    wb_stall_i = 1'b0;
    drive_m(1, 0, 0, 0, 0, 0, 0);
    rst_i = 1'b0;
    smp();
    check("t1_grant_after", grant_o, GRANT_NONE);

    next();
    check("xfer_q_drained", xfer_q.size(), 0);
    check("ack_q_drained", ack_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
